hilo_mult_seq: RTL and testbench

- Iterative shift-add multiply sequencer that owns the HI/LO register pair of the pipelined MIPS-subset core.
- Launched by mult/multu in EX (enhilo_EX=1). Runs one multiplier bit per cycle.
- Interlocks the pipeline: raises stall while a new mult, mfhi or mflo would observe or disturb an in-flight product.
- Sits beside the ALU in EX. Its hi/lo outputs feed the WB regsel mux (1=HI, 2=LO).

---
 rtl/hilo_pkg.sv | 22 ++
 rtl/mult_shift_add_dp.sv | 76 +++++++
 rtl/hilo_mult_seq.sv | 120 ++++++++++++
 tb/tb_hilo_mult_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg : shared types and encodings for the HI/LO multiply sequencer. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package hilo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mult_state_t;

  localparam logic [3:0] ALU_MULT  = 4'b0110;
  localparam logic [3:0] ALU_MULTU = 4'b0111;

  localparam logic [1:0] REGSEL_HI = 2'b01;
  localparam logic [1:0] REGSEL_LO = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mult_shift_add_dp.sv
// -----------------------------------------------------------------------------
// mult_shift_add_dp : shift-add multiply datapath with final sign fix-up.
// Optional barrel shift in FIX under HILO_MULT_EARLY_EXIT_EN. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mult_shift_add_dp
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef HILO_MULT_EARLY_EXIT_EN
  input  logic [CNT_W-1:0]   fix_shift,
  output logic               mplier_last,
`endif
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               sign;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_fix;

  // Two's-complement negate of the most negative value is itself, which is
  // exactly the unsigned magnitude we want.
  always_comb begin
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
    addend = mplier[0] ? mcand : '0;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign   <= 1'b0;
    end else if (load) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc    <= '0;
      sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc    <= {sum, acc[WIDTH-1:1]};
      mplier <= mplier >> 1;
    end
  end

`ifdef HILO_MULT_EARLY_EXIT_EN
  // An early exit leaves the product short of its final alignment.
  assign acc_fix     = acc >> fix_shift;
  assign mplier_last = (mplier[WIDTH-1:1] == '0);
`else
  assign acc_fix     = acc;
`endif

  assign product = sign ? -acc_fix : acc_fix;

endmodule

`default_nettype wire

// File: rtl/hilo_mult_seq.sv
// -----------------------------------------------------------------------------
// hilo_mult_seq : iterative mult/multu sequencer owning HI/LO, with pipeline
// interlock. Optional early exit: HILO_MULT_EARLY_EXIT_EN. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module hilo_mult_seq
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t        state;
  mult_state_t        state_next;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               run_exit;
  logic [2*WIDTH-1:0] product;

`ifdef HILO_MULT_EARLY_EXIT_EN
  logic               mplier_last;
  logic [CNT_W-1:0]   fix_shift;

  // cnt is frozen on the exit edge, so it indexes the last RUN cycle.
  assign fix_shift = CNT_LAST - cnt;
  assign run_exit  = (cnt == CNT_LAST) | mplier_last;
`else
  assign run_exit  = (cnt == CNT_LAST);
`endif

  mult_shift_add_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
`ifdef HILO_MULT_EARLY_EXIT_EN
    .fix_shift   (fix_shift),
    .mplier_last (mplier_last),
`endif
    .product     (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (run_exit) begin
          state_next = S_FIX;
        end
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    busy  = (state != S_IDLE);
    done  = (state == S_FIX);
    stall = busy & (start | rd_req);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step && !run_exit) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      {hi, lo} <= product;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_hilo_mult_seq : directed scoreboard bench for hilo_mult_seq. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_hilo_mult_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int               vectors     = 0;
  int               miscompares = 0;
  logic [63:0]      sb_q[$];
  logic [63:0]      cur;

  always #5 clk = ~clk;

  hilo_mult_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .rd_req    (rd_req),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic sg);
    longint sa, sb;
    if (sg) begin
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      return 64'(sa * sb);
    end
    return {32'b0, ma} * {32'b0, mb};
  endfunction

  // Edges from acceptance to the HI/LO write edge.
  function automatic int lat_of(input logic [31:0] mb, input logic sg);
    logic [31:0] m;
    int          h;
    m = (sg && mb[31]) ? -mb : mb;
    h = 0;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
`ifdef HILO_MULT_EARLY_EXIT_EN
    return h + 2;
`else
    return (m == 32'd0) ? WIDTH + 1 + h : WIDTH + 1;
`endif
  endfunction

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic sg,
                       output int lat);
    a         = ia;
    b         = ib;
    is_signed = sg;
    start     = 1'b1;
    sb_q.push_back(model(ia, ib, sg));
    lat       = lat_of(ib, sg);
  endtask

  task automatic accept(input bit hold);
    @(posedge clk);
    #1;
    if (!hold) begin
      start     = 1'b0;
      a         = $urandom;
      b         = $urandom;
      is_signed = 1'($urandom);
    end
  endtask

  task automatic wait_result(input int lat, input int rd_from, input string tag);
    int          dc;
    logic [63:0] exp;
    dc = 0;
    for (int n = 1; n <= lat; n++) begin
      @(posedge clk);
      #1;
      if (rd_from != 0 && n == rd_from) rd_req = 1'b1;
      if (done) dc++;
      if (n == 1 && lat > 2) begin
        check1({tag, ":busy_run"}, busy, 1'b1);
        check1({tag, ":stall_run"}, stall, start | rd_req);
      end
      if (n == lat - 1) begin
        check1({tag, ":done_fix"}, done, 1'b1);
        check1({tag, ":stall_fix"}, stall, start | rd_req);
        check64({tag, ":hold"}, {hi, lo}, cur);
      end
      if (n == lat) begin
        check_int({tag, ":done_cycles"}, dc, 1);
        check1({tag, ":busy_idle"}, busy, 1'b0);
        check1({tag, ":stall_idle"}, stall, 1'b0);
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL %s: scoreboard empty, observed %h", tag, {hi, lo});
        end else begin
          exp = sb_q.pop_front();
          check64({tag, ":hilo"}, {hi, lo}, exp);
          cur = exp;
        end
      end
    end
    rd_req = 1'b0;
  endtask

  initial begin : main
    int lat, lat2;
    rst       = 1'b1;
    start     = 1'b0;
    rd_req    = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    cur       = '0;

    repeat (2) @(posedge clk);
    #1;
    check64("reset:hilo", {hi, lo}, 64'd0);
    check1("reset:busy", busy, 1'b0);
    check1("reset:done", done, 1'b0);
    check1("reset:stall", stall, 1'b0);
    rst = 1'b0;

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    accept(0);
    wait_result(lat, 0, "multu_max");

    issue(32'hFFFF_FFFD, 32'd5, 1'b1, lat);
    accept(0);
    wait_result(lat, 0, "mult_neg3x5");

    issue(32'h8000_0000, 32'h8000_0000, 1'b1, lat);
    accept(0);
    wait_result(lat, 0, "mult_minxmin");

    issue(32'd6, 32'd7, 1'b0, lat);
    accept(0);
    wait_result(lat, (lat > 6) ? 5 : 1, "multu_6x7_rd");

    rd_req = 1'b1;
    #1;
    check1("rd_idle:stall", stall, 1'b0);
    check64("rd_idle:hilo", {hi, lo}, 64'd42);
    rd_req = 1'b0;

    issue(32'h0001_2345, 32'h0000_0777, 1'b0, lat);
    accept(1);
    a         = 32'd2;
    b         = 32'd3;
    is_signed = 1'b0;
    wait_result(lat, 0, "b2b_first");
    issue(32'd2, 32'd3, 1'b0, lat2);
    accept(0);
    wait_result(lat2, 0, "b2b_second");

    issue(32'h0000_1234, 32'h0000_5678, 1'b0, lat);
    accept(0);
    repeat (9) @(posedge clk);
    #1;
    rd_req = 1'b1;
    #1;
    check1("midrun:stall", stall, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check64("async_rst:hilo", {hi, lo}, 64'd0);
    check1("async_rst:busy", busy, 1'b0);
    check1("async_rst:stall", stall, 1'b0);
    #1;
    rst    = 1'b0;
    rd_req = 1'b0;
    void'(sb_q.pop_back());
    cur = '0;

    issue(32'd4, 32'd4, 1'b0, lat);
    accept(0);
    wait_result(lat, 0, "multu_4x4");

    issue(32'd7, 32'd3, 1'b0, lat);
    accept(0);
    wait_result(lat, 0, "multu_7x3");

    issue(32'h0000_1234, 32'd0, 1'b0, lat);
    accept(0);
    wait_result(lat, 0, "multu_bzero");

    for (int i = 0; i < 4; i++) begin
      issue($urandom, $urandom, 1'(i), lat);
      accept(0);
      wait_result(lat, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
